// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/forward sequencer for the 5-stage RV32I core.
// Ports: hazard regs in, F/D/E/M/W stall/flush/enable and fwd selects out.
// Optional perf counters (StallCnt_o, FlushCnt_o) under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic RegWriteM_i,
  input  logic RegWriteW_i,
  input  logic [1:0] ResultSrcE_i,
  input  logic PCSrcE_i,
  input  logic MemReqM_i,
  input  logic MemReadyM_i,
  output logic StallF_o,
  output logic StallD_o,
  output logic StallE_o,
  output logic FlushD_o,
  output logic FlushE_o,
  output logic FlushW_o,
  output logic EnM_o,
  output logic [1:0] ForwardAE_o,
  output logic [1:0] ForwardBE_o,
  output logic MemErr_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
`endif
);

  localparam int BW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [BW-1:0] BOOT_INIT = BW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MEM_WAIT
  } state_e;

  state_e state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [WW-1:0] wait_q, wait_d;
  logic err_q, err_d;

  logic lw_stall;
  logic mem_stall;
  logic timeout;
  logic hold;

  assign lw_stall = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign mem_stall = MemReqM_i && !MemReadyM_i;
  assign timeout = (state_q == MEM_WAIT) && (wait_q == WAIT_LAST) &&
                   !MemReadyM_i;
  // A timeout forces one release cycle even though memory is still busy.
  assign hold = mem_stall && !timeout;

  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i))
      ForwardAE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i))
      ForwardAE_o = 2'b01;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i))
      ForwardBE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i))
      ForwardBE_o = 2'b01;
  end

  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    EnM_o    = 1'b1;
    if (state_q == BOOT) begin
      StallF_o = 1'b1;
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (hold) begin
      // Memory freeze wins; the E-stage branch re-resolves after release.
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      FlushW_o = 1'b1;
      EnM_o    = 1'b0;
    end else begin
      StallF_o = lw_stall;
      StallD_o = lw_stall;
      FlushD_o = PCSrcE_i;
      FlushE_o = lw_stall | PCSrcE_i;
    end
  end

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      BOOT: begin
        if (boot_q == '0) state_d = RUN;
        else boot_d = boot_q - BW'(1);
      end
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end else if (!mem_stall) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      boot_q  <= BOOT_INIT;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign MemErr_o = err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != BOOT) && StallF_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == RUN) && PCSrcE_i && !mem_stall &&
          (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Runs with FLUSH_CYCLES=4 and MEM_TIMEOUT=8.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
  logic [4:0] RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic [1:0] ResultSrcE = 2'b00;
  logic PCSrcE = 1'b0, MemReq = 1'b0, MemReady = 1'b0;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushW, EnM;
  logic [1:0] FwdA, FwdB;
  logic MemErr;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // {StallF,StallD,StallE,FlushD,FlushE,FlushW,EnM}
  logic [6:0] ctrl;
  assign ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushW, EnM};

  localparam logic [6:0] C_BOOT = 7'b1001111;
  localparam logic [6:0] C_IDLE = 7'b0000001;
  localparam logic [6:0] C_HOLD = 7'b1110010;
  localparam logic [6:0] C_LU   = 7'b1100101;
  localparam logic [6:0] C_LUBR = 7'b1101101;
  localparam logic [6:0] C_BR   = 7'b0001101;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .REGISTER_ADDRESS_WIDTH(5),
    .FLUSH_CYCLES(4),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .Rs1D_i(Rs1D),
    .Rs2D_i(Rs2D),
    .Rs1E_i(Rs1E),
    .Rs2E_i(Rs2E),
    .RdE_i(RdE),
    .RdM_i(RdM),
    .RdW_i(RdW),
    .RegWriteM_i(RegWriteM),
    .RegWriteW_i(RegWriteW),
    .ResultSrcE_i(ResultSrcE),
    .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReq),
    .MemReadyM_i(MemReady),
    .StallF_o(StallF),
    .StallD_o(StallD),
    .StallE_o(StallE),
    .FlushD_o(FlushD),
    .FlushE_o(FlushE),
    .FlushW_o(FlushW),
    .EnM_o(EnM),
    .ForwardAE_o(FwdA),
    .ForwardBE_o(FwdB),
    .MemErr_o(MemErr)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .StallCnt_o(StallCnt),
    .FlushCnt_o(FlushCnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_chk++;
    if (ctrl !== C_BOOT) begin
      n_fail++;
      $display("FAIL in_reset ctrl=%b exp=%b", ctrl, C_BOOT);
    end
    n_chk++;
    if (MemErr !== 1'b0) begin
      n_fail++;
      $display("FAIL in_reset_err got=%b exp=0", MemErr);
    end
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        tick();
        #1;
      end
      n_chk++;
      if (ctrl !== C_BOOT) begin
        n_fail++;
        $display("FAIL boot_c%0d ctrl=%b exp=%b", i, ctrl, C_BOOT);
      end
    end
    tick();
    #1;
    n_chk++;
    if (ctrl !== C_IDLE) begin
      n_fail++;
      $display("FAIL first_run ctrl=%b exp=%b", ctrl, C_IDLE);
    end
  endtask

  task automatic test_forwarding;
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    Rs1E = 5; Rs2E = 0;
    #1;
    n_chk++;
    if ({FwdA, FwdB} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fwd_m_pri got=%b exp=1000", {FwdA, FwdB});
    end
    RegWriteM = 0;
    #1;
    n_chk++;
    if ({FwdA, FwdB} !== 4'b0100) begin
      n_fail++;
      $display("FAIL fwd_w got=%b exp=0100", {FwdA, FwdB});
    end
    RegWriteM = 1; RdM = 0; Rs2E = 5;
    #1;
    n_chk++;
    if ({FwdA, FwdB} !== 4'b0101) begin
      n_fail++;
      $display("FAIL fwd_rd0 got=%b exp=0101", {FwdA, FwdB});
    end
    RdM = 9; Rs2E = 9; RegWriteW = 0;
    #1;
    n_chk++;
    if ({FwdA, FwdB} !== 4'b0010) begin
      n_fail++;
      $display("FAIL fwd_b_m got=%b exp=0010", {FwdA, FwdB});
    end
    RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
    Rs1E = 0; Rs2E = 0;
  endtask

  task automatic test_load_use;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    n_chk++;
    if (ctrl !== C_LU) begin
      n_fail++;
      $display("FAIL lu_rs2 ctrl=%b exp=%b", ctrl, C_LU);
    end
    RdE = 0; Rs2D = 0;
    #1;
    n_chk++;
    if (ctrl !== C_IDLE) begin
      n_fail++;
      $display("FAIL lu_rd0 ctrl=%b exp=%b", ctrl, C_IDLE);
    end
    RdE = 7; Rs1D = 7;
    #1;
    n_chk++;
    if (ctrl !== C_LU) begin
      n_fail++;
      $display("FAIL lu_rs1 ctrl=%b exp=%b", ctrl, C_LU);
    end
    PCSrcE = 1;
    #1;
    n_chk++;
    if (ctrl !== C_LUBR) begin
      n_fail++;
      $display("FAIL lu_branch ctrl=%b exp=%b", ctrl, C_LUBR);
    end
    ResultSrcE = 2'b00;
    #1;
    n_chk++;
    if (ctrl !== C_BR) begin
      n_fail++;
      $display("FAIL branch ctrl=%b exp=%b", ctrl, C_BR);
    end
    PCSrcE = 0; RdE = 0; Rs1D = 0;
  endtask

  task automatic test_mem_wait;
    tick();
    MemReq = 1; MemReady = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) PCSrcE = 1;
      #1;
      n_chk++;
      if (ctrl !== C_HOLD) begin
        n_fail++;
        $display("FAIL memwait_c%0d ctrl=%b exp=%b", i, ctrl, C_HOLD);
      end
      tick();
    end
    MemReady = 1;
    #1;
    n_chk++;
    if (ctrl !== C_BR) begin
      n_fail++;
      $display("FAIL mem_release ctrl=%b exp=%b", ctrl, C_BR);
    end
    tick();
    MemReq = 0; MemReady = 0; PCSrcE = 0;
    #1;
    n_chk++;
    if ({ctrl, MemErr} !== {C_IDLE, 1'b0}) begin
      n_fail++;
      $display("FAIL post_wait got=%b exp=%b", {ctrl, MemErr},
               {C_IDLE, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    MemReq = 1; MemReady = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_chk++;
      if (ctrl !== C_IDLE) begin
        n_fail++;
        $display("FAIL single_cyc_%0d ctrl=%b exp=%b", i, ctrl, C_IDLE);
      end
      tick();
    end
    MemReq = 0; MemReady = 0;
    tick();
    #1;
    n_chk++;
    if (ctrl !== C_IDLE) begin
      n_fail++;
      $display("FAIL b2b_idle ctrl=%b exp=%b", ctrl, C_IDLE);
    end
  endtask

  task automatic test_timeout;
    tick();
    MemReq = 1; MemReady = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      n_chk++;
      if (ctrl !== ((i < 8) ? C_HOLD : C_IDLE)) begin
        n_fail++;
        $display("FAIL timeout_c%0d ctrl=%b exp=%b", i, ctrl,
                 (i < 8) ? C_HOLD : C_IDLE);
      end
      if (i == 8) begin
        n_chk++;
        if (MemErr !== 1'b0) begin
          n_fail++;
          $display("FAIL err_early got=%b exp=0", MemErr);
        end
      end
      tick();
    end
    MemReq = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_chk++;
      if (MemErr !== 1'b1) begin
        n_fail++;
        $display("FAIL err_sticky_%0d got=%b exp=1", i, MemErr);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait;
    MemReq = 1; MemReady = 0;
    tick();
    tick();
    #1;
    n_chk++;
    if (ctrl !== C_HOLD) begin
      n_fail++;
      $display("FAIL pre_rst_hold ctrl=%b exp=%b", ctrl, C_HOLD);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if ({ctrl, MemErr} !== {C_BOOT, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst got=%b exp=%b", {ctrl, MemErr},
               {C_BOOT, 1'b0});
    end
    tick();
    rst_n = 1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      #1;
      n_chk++;
      if (ctrl !== C_BOOT) begin
        n_fail++;
        $display("FAIL boot_memreq_c%0d ctrl=%b exp=%b", i, ctrl, C_BOOT);
      end
    end
    MemReq = 0;
    tick();
    #1;
    n_chk++;
    if (ctrl !== C_IDLE) begin
      n_fail++;
      $display("FAIL reboot_run ctrl=%b exp=%b", ctrl, C_IDLE);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf;
    n_chk++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin
      n_fail++;
      $display("FAIL perf_reset stall=%0d flush=%0d exp=0/0",
               StallCnt, FlushCnt);
    end
    tick();
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    tick();
    ResultSrcE = 2'b00; RdE = 0; Rs1D = 0;
    MemReq = 1; MemReady = 0;
    tick();
    tick();
    MemReady = 1;
    tick();
    MemReq = 0; MemReady = 0; PCSrcE = 1;
    tick();
    PCSrcE = 0;
    #1;
    n_chk++;
    if ({StallCnt, FlushCnt} !== {32'd3, 32'd1}) begin
      n_fail++;
      $display("FAIL perf_counts stall=%0d flush=%0d exp=3/1",
               StallCnt, FlushCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control and hazard sequencer for the 5-stage RV32I core. Drives the stall, flush and enable inputs of the F/D/E/M/W pipeline registers. Generates E-stage forwarding selects, detects load-use and taken-branch hazards, and freezes the pipeline while a data-memory access in M is not ready. Sits beside the datapath and is instantiated once in the core top.

## Interface
Parameters:
- REGISTER_ADDRESS_WIDTH, 5, register index width
- FLUSH_CYCLES, 4, post-reset flush length in cycles (≥1)
- MEM_TIMEOUT, 64, max MEM_WAIT cycles before error (≥2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- Rs1D_i, Rs2D_i  in  REGISTER_ADDRESS_WIDTH  D-stage source regs
- Rs1E_i, Rs2E_i, RdE_i  in  REGISTER_ADDRESS_WIDTH  E-stage regs
- RdM_i, RdW_i  in  REGISTER_ADDRESS_WIDTH  M/W destination regs
- RegWriteM_i, RegWriteW_i  in  1  M/W write enables
- ResultSrcE_i  in  2  E-stage result select; 2'b01 = load
- PCSrcE_i  in  1  branch/jump taken in E
- MemReqM_i  in  1  M-stage load/store active
- MemReadyM_i  in  1  data memory completes this cycle
- StallF_o, StallD_o, StallE_o  out  1  hold F, F→D, D→E registers
- FlushD_o, FlushE_o, FlushW_o  out  1  bubble into D, E, W registers
- EnM_o  out  1  enable of E→M register (0 = freeze)
- ForwardAE_o, ForwardBE_o  out  2  00 regfile, 01 W result, 10 M ALU result
- MemErr_o  out  1  sticky memory-timeout flag

## Operation
- Forwarding (combinational, all states): ForwardAE = 10 if RegWriteM && RdM≠0 && RdM==Rs1E; else 01 if RegWriteW && RdW≠0 && RdW==Rs1E; else 00. M has priority over W. ForwardBE uses the same rule with Rs2E.
- lwStall = (ResultSrcE==01) && RdE≠0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = MemReqM && !MemReadyM.
- FSM states: BOOT, RUN, MEM_WAIT.
- BOOT: StallF=1, FlushD=FlushE=FlushW=1, EnM=1, StallD=StallE=0. Down-counter runs from FLUSH_CYCLES-1; goes to RUN when it reaches 0.
- RUN, memStall=0:
  - StallF=StallD=lwStall; StallE=0.
  - FlushD=PCSrcE; FlushE=lwStall|PCSrcE; FlushW=0; EnM=1.
- RUN or MEM_WAIT, memStall=1 (overrides lwStall and PCSrcE):
  - StallF=StallD=StallE=1, EnM=0, FlushW=1.
  - FlushD=FlushE=0. The branch in E re-resolves after release.
- RUN→MEM_WAIT when memStall=1. The wait counter loads 1.
- MEM_WAIT→RUN when MemReadyM=1. That cycle uses RUN outputs.
- MEM_WAIT timeout: when the counter reaches MEM_TIMEOUT-1 with MemReadyM=0:
  - set MemErr_o=1;
  - force release for that cycle (RUN outputs, memStall ignored);
  - return to RUN.
- MemErr_o clears only on reset.
- Wait counter width is clog2(MEM_TIMEOUT)+1. It never wraps.

## Timing
- Registered elements: FSM state, boot counter, wait counter, MemErr_o, perf counters. Everything else is combinational from inputs and state, with zero latency.
- Reset (rst_ni=0, asynchronous): state=BOOT, boot counter=FLUSH_CYCLES-1, wait counter=0, MemErr_o=0.
- Outputs during reset follow BOOT: StallF=1, StallD=0, StallE=0, FlushD=1, FlushE=1, FlushW=1, EnM=1. Forward selects follow their inputs.
- First RUN cycle is FLUSH_CYCLES cycles after rst_ni rises.
- MemReadyM in the same cycle as MemReqM: no stall and no state change (single-cycle memory).
- Reset asserted mid-MEM_WAIT: immediate return to BOOT; wait count discarded.
- lwStall and PCSrcE together: FlushE=1, FlushD=1, StallF=StallD=1. The load-use hold on F/D applies while D is flushed.
- MemReqM/MemReadyM are ignored in BOOT.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs StallCnt_o[31:0] and FlushCnt_o[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - StallCnt_o increments in each RUN/MEM_WAIT cycle with StallF=1.
  - FlushCnt_o increments in each RUN cycle with PCSrcE=1 and memStall=0.
- PIPE_CTRL_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Boot: release rst_ni with FLUSH_CYCLES=4 -> StallF=1, FlushD/E/W=1 for exactly 4 cycles, then all stall/flush outputs 0 and EnM=1.
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1 in the same cycle. With RdE=0 -> no stall.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF/D/E=1, EnM=0, FlushW=1 for 3 cycles, release on the ready cycle, state RUN. A PCSrcE=1 during the wait produces no flush.
- Timeout: MEM_TIMEOUT=8, MemReadyM held 0 -> release on the 8th stalled cycle and MemErr_o=1. It stays 1 until rst_ni=0.
- Perf (PIPE_CTRL_PERF_EN): one load-use plus 2 memory-wait cycles and one taken branch -> StallCnt_o=3, FlushCnt_o=1.
